// File: rtl/cache_refill_unit.sv
// cache_refill_unit: memory-side refill engine. It takes one miss from the MSHR and
// reads the block as a beat burst. On a store miss it merges the store word into the
// block. It then writes the block into the L1 data cache as a one-cycle repair.
// It also holds one dirty evicted block and writes it back before the next refill starts.
module cache_refill_unit #(
  parameter int BLOCK_SIZE = 128,
  parameter int BEAT_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ROB_IDX_W  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [31:0]           req_data_i,
  input  logic [ROB_IDX_W-1:0]  req_rob_idx_i,
  input  logic                  req_is_store_i,
  output logic                  req_ready_o,
  input  logic                  wb_en_i,
  input  logic [ADDR_W-1:0]     wb_addr_i,
  input  logic [BLOCK_SIZE-1:0] wb_block_i,
  output logic                  wb_full_o,
  output logic                  mem_rd_req_o,
  output logic [ADDR_W-1:0]     mem_rd_addr_o,
  input  logic                  mem_rd_gnt_i,
  input  logic                  mem_rd_valid_i,
  input  logic [BEAT_W-1:0]     mem_rd_data_i,
  output logic                  mem_wr_valid_o,
  output logic [ADDR_W-1:0]     mem_wr_addr_o,
  output logic [BEAT_W-1:0]     mem_wr_data_o,
  input  logic                  mem_wr_ack_i,
  output logic                  repair_en_o,
  output logic [ADDR_W-1:0]     repair_addr_o,
  output logic [BLOCK_SIZE-1:0] repair_data_o,
  output logic                  repair_dirty_o,
  output logic                  repair_done_o,
  output logic [ROB_IDX_W-1:0]  repair_rob_idx_o
);

  localparam int BEATS  = BLOCK_SIZE / BEAT_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFF_W  = $clog2(BLOCK_SIZE / 8);
  localparam int WORDS  = BLOCK_SIZE / 32;
  localparam int WSEL_W = OFF_W - 2;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WB_BEATS, RD_REQ, RD_BEATS, REPAIR} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       beat_cnt_reg, beat_cnt_next;
  logic                   wb_full_reg;
  logic [ADDR_W-1:0]      wb_addr_reg;
  logic [BLOCK_SIZE-1:0]  wb_block_reg;
  logic [ADDR_W-1:0]      req_addr_reg;
  logic [WSEL_W-1:0]      req_wsel_reg;
  logic [31:0]            req_data_reg;
  logic [ROB_IDX_W-1:0]   req_rob_reg;
  logic                   req_store_reg;
  logic [BEAT_W-1:0]      fill_reg [BEATS];

  logic [BLOCK_SIZE-1:0]  fill_block;
  logic [BLOCK_SIZE-1:0]  merged_block;
  logic [BEAT_W-1:0]      wb_beat [BEATS];
  logic                   req_accept;
  logic                   wb_capture;
  logic                   wr_last;
  logic                   rd_beat;
  logic                   unused_addr_bits;

  // The byte offset inside the store word does not matter; only the word select does.
  assign unused_addr_bits = ^req_addr_i[1:0];

  assign req_accept = req_valid_i && req_ready_o;
  assign wb_capture = wb_en_i && !wb_full_reg;
  assign wr_last    = (state_reg == WB_BEATS) && mem_wr_ack_i && (beat_cnt_reg == LAST_BEAT);
  assign rd_beat    = (state_reg == RD_BEATS) && mem_rd_valid_i;
  assign wb_full_o  = wb_full_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      assign fill_block[gi*BEAT_W +: BEAT_W] = fill_reg[gi];
      assign wb_beat[gi] = wb_block_reg[gi*BEAT_W +: BEAT_W];
    end
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      assign merged_block[gi*32 +: 32] =
        (req_store_reg && (req_wsel_reg == WSEL_W'(gi))) ? req_data_reg : fill_block[gi*32 +: 32];
    end
  endgenerate

  // State and shared beat counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // Next-state and outputs. Outputs stay zero outside their own state.
  always_comb begin
    state_next       = state_reg;
    beat_cnt_next    = beat_cnt_reg;
    req_ready_o      = 1'b0;
    mem_rd_req_o     = 1'b0;
    mem_rd_addr_o    = '0;
    mem_wr_valid_o   = 1'b0;
    mem_wr_addr_o    = '0;
    mem_wr_data_o    = '0;
    repair_en_o      = 1'b0;
    repair_done_o    = 1'b0;
    repair_addr_o    = '0;
    repair_data_o    = '0;
    repair_dirty_o   = 1'b0;
    repair_rob_idx_o = '0;
    case (state_reg)
      IDLE: begin
        req_ready_o = !wb_full_reg && !wb_en_i;
        // A pending writeback always drains before a new refill reads memory.
        if (wb_full_reg) begin
          state_next = WB_BEATS;
        end else if (req_valid_i && !wb_en_i) begin
          state_next = RD_REQ;
        end
      end
      WB_BEATS: begin
        mem_wr_valid_o = 1'b1;
        mem_wr_addr_o  = wb_addr_reg;
        mem_wr_data_o  = wb_beat[beat_cnt_reg];
        if (mem_wr_ack_i) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          if (beat_cnt_reg == LAST_BEAT) begin
            state_next = IDLE;
          end
        end
      end
      RD_REQ: begin
        mem_rd_req_o  = 1'b1;
        mem_rd_addr_o = req_addr_reg;
        if (mem_rd_gnt_i) begin
          state_next = RD_BEATS;
        end
      end
      RD_BEATS: begin
        if (mem_rd_valid_i) begin
          beat_cnt_next = beat_cnt_reg + 1'b1;
          if (beat_cnt_reg == LAST_BEAT) begin
            state_next = REPAIR;
          end
        end
      end
      REPAIR: begin
        repair_en_o      = 1'b1;
        repair_done_o    = 1'b1;
        repair_addr_o    = req_addr_reg;
        repair_data_o    = merged_block;
        repair_dirty_o   = req_store_reg;
        repair_rob_idx_o = req_rob_reg;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Writeback buffer: filled whenever free, freed by the ack of the final write beat.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wb_full_reg  <= 1'b0;
      wb_addr_reg  <= '0;
      wb_block_reg <= '0;
    end else if (wb_capture) begin
      wb_full_reg  <= 1'b1;
      wb_addr_reg  <= wb_addr_i;
      wb_block_reg <= wb_block_i;
    end else if (wr_last) begin
      wb_full_reg  <= 1'b0;
    end
  end

  // Request latch. The address is stored block-aligned, and the store word select is kept separately.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      req_addr_reg  <= '0;
      req_wsel_reg  <= '0;
      req_data_reg  <= '0;
      req_rob_reg   <= '0;
      req_store_reg <= 1'b0;
    end else if (req_accept) begin
      req_addr_reg  <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      req_wsel_reg  <= req_addr_i[OFF_W-1:2];
      req_data_reg  <= req_data_i;
      req_rob_reg   <= req_rob_idx_i;
      req_store_reg <= req_is_store_i;
    end
  end

  // Fill buffer: each read beat lands in its slot. Beats outside RD_BEATS are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < BEATS; i++) begin
        fill_reg[i] <= '0;
      end
    end else if (rd_beat) begin
      fill_reg[beat_cnt_reg] <= mem_rd_data_i;
    end
  end

endmodule
